// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one Data_Memory port between the ALU writeback
// port (0) and the load/store unit (1); one transaction in flight at a time.
module dmem_port_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 72
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_0,
    input  logic              req_we_0,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [DATA_W-1:0] req_wdata_0,
    output logic              req_ready_0,
    output logic              rsp_valid_0,
    input  logic              rsp_ready_0,
    input  logic              req_valid_1,
    input  logic              req_we_1,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [DATA_W-1:0] req_wdata_1,
    output logic              req_ready_1,
    output logic              rsp_valid_1,
    input  logic              rsp_ready_1,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_rr_ptr;
    logic                r_op_we;
    logic                r_owner;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_mem_we;
    logic                r_rsp_valid_0;
    logic                r_rsp_valid_1;

    logic                w_grant_0;
    logic                w_grant_1;
    logic                w_accept;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_rsp_taken;

    // Grant only in IDLE; rr_ptr breaks the tie when both ports ask at once.
    always_comb begin
        w_grant_0 = 1'b0;
        w_grant_1 = 1'b0;
        if (r_state == IDLE) begin
            if (req_valid_0 && req_valid_1) begin
                w_grant_0 = ~r_rr_ptr;
                w_grant_1 = r_rr_ptr;
            end else begin
                w_grant_0 = req_valid_0;
                w_grant_1 = req_valid_1;
            end
        end
    end

    assign w_accept    = w_grant_0 | w_grant_1;
    assign w_sel_we    = w_grant_1 ? req_we_1    : req_we_0;
    assign w_sel_addr  = w_grant_1 ? req_addr_1  : req_addr_0;
    assign w_sel_wdata = w_grant_1 ? req_wdata_1 : req_wdata_0;
    assign w_rsp_taken = r_owner ? rsp_ready_1 : rsp_ready_0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_rr_ptr      <= 1'b0;
            r_op_we       <= 1'b0;
            r_owner       <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_mem_we      <= 1'b0;
            r_rsp_valid_0 <= 1'b0;
            r_rsp_valid_1 <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op_we  <= w_sel_we;
                        r_addr   <= w_sel_addr;
                        r_owner  <= w_grant_1;
                        r_rr_ptr <= ~w_grant_1;
                        r_mem_we <= w_sel_we;
                        // Write data only moves on writes so mem_wdata keeps its last issued value.
                        if (w_sel_we) begin
                            r_wdata <= w_sel_wdata;
                        end
                        r_state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_mem_we <= 1'b0;
                    if (r_op_we) begin
                        r_state <= IDLE;
                    end else begin
                        r_rdata       <= mem_rdata;
                        r_rsp_valid_0 <= ~r_owner;
                        r_rsp_valid_1 <= r_owner;
                        r_state       <= RESP;
                    end
                end
                RESP: begin
                    if (w_rsp_taken) begin
                        r_rsp_valid_0 <= 1'b0;
                        r_rsp_valid_1 <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_mem_we <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_0 = w_grant_0;
    assign req_ready_1 = w_grant_1;
    assign rsp_valid_0 = r_rsp_valid_0;
    assign rsp_valid_1 = r_rsp_valid_1;
    assign rsp_rdata   = r_rdata;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed and randomized checks of dmem_port_arbiter against a transaction-level
// model: round-robin grant order, write issue timing, read responses and reset.
module tb_dmem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        req_valid_0, req_we_0, req_ready_0, rsp_valid_0, rsp_ready_0;
    logic [6:0]  req_addr_0;
    logic [71:0] req_wdata_0;
    logic        req_valid_1, req_we_1, req_ready_1, rsp_valid_1, rsp_ready_1;
    logic [6:0]  req_addr_1;
    logic [71:0] req_wdata_1;
    logic [71:0] rsp_rdata;
    logic        mem_we;
    logic [6:0]  mem_addr;
    logic [71:0] mem_wdata;
    logic [71:0] mem_rdata;
    logic        busy;

    dmem_port_arbiter #(.ADDR_W(7), .DATA_W(72)) dut (
        .clk(clk), .reset(reset),
        .req_valid_0(req_valid_0), .req_we_0(req_we_0), .req_addr_0(req_addr_0),
        .req_wdata_0(req_wdata_0), .req_ready_0(req_ready_0),
        .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0),
        .req_valid_1(req_valid_1), .req_we_1(req_we_1), .req_addr_1(req_addr_1),
        .req_wdata_1(req_wdata_1), .req_ready_1(req_ready_1),
        .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1),
        .rsp_rdata(rsp_rdata), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [6:0]  addr;
        logic [71:0] wdata;
    } req_t;

    // Memory the DUT drives, plus a write log of (address, cycle).
    logic [71:0] mem [128];
    int          cyc = 0;
    int          wlog_cyc[$];
    logic [6:0]  wlog_addr[$];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wlog_addr.push_back(mem_addr);
            wlog_cyc.push_back(cyc);
        end
    end

    // Transaction-level reference state.
    logic [71:0] mem_ref [128];
    bit          turn;
    int          issue_left;
    bit          iss_we;
    logic [6:0]  iss_addr;
    logic [71:0] iss_data;
    bit          await_rsp;
    bit          await_port;
    logic [71:0] await_data;
    req_t        q0[$], q1[$];
    int          grant_log[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
            $error("check %s differs", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        turn       = 1'b0;
        issue_left = 0;
        await_rsp  = 1'b0;
    endtask

    task automatic idle_inputs();
        req_valid_0 = 0; req_we_0 = 0; req_addr_0 = '0; req_wdata_0 = '0; rsp_ready_0 = 0;
        req_valid_1 = 0; req_we_1 = 0; req_addr_1 = '0; req_wdata_1 = '0; rsp_ready_1 = 0;
    endtask

    // Drives queued requests on both ports and checks every cycle against the model.
    task automatic run_ports(input bit rnd, input int max_cyc);
        int   n;
        bit   v0, v1, free, e_r0, e_r1, ev0, ev1, rr0, rr1, done;
        req_t r;
        bit   p;
        n = 0; v0 = 0; v1 = 0;
        grant_log.delete();
        while ((q0.size() > 0 || q1.size() > 0 || issue_left > 0 || await_rsp) && n < max_cyc) begin
            if (!v0 && q0.size() > 0 && (!rnd || $urandom_range(0, 9) < 6)) v0 = 1;
            if (!v1 && q1.size() > 0 && (!rnd || $urandom_range(0, 9) < 6)) v1 = 1;
            req_valid_0 = v0;
            if (v0) begin req_we_0 = q0[0].we; req_addr_0 = q0[0].addr; req_wdata_0 = q0[0].wdata; end
            req_valid_1 = v1;
            if (v1) begin req_we_1 = q1[0].we; req_addr_1 = q1[0].addr; req_wdata_1 = q1[0].wdata; end
            rsp_ready_0 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            rsp_ready_1 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            free = !await_rsp && issue_left == 0;
            e_r0 = free && v0 && (!v1 || turn == 1'b0);
            e_r1 = free && v1 && (!v0 || turn == 1'b1);
            ev0  = await_rsp && issue_left == 0 && await_port == 1'b0;
            ev1  = await_rsp && issue_left == 0 && await_port == 1'b1;
            check("req_ready_0", req_ready_0, e_r0);
            check("req_ready_1", req_ready_1, e_r1);
            check("busy", busy, !free);
            check("rsp_valid_0", rsp_valid_0, ev0);
            check("rsp_valid_1", rsp_valid_1, ev1);
            if (ev0 || ev1) check("rsp_rdata", rsp_rdata, await_data);
            check("mem_we", mem_we, issue_left > 0 && iss_we);
            if (issue_left > 0) check("mem_addr", mem_addr, iss_addr);
            if (issue_left > 0 && iss_we) check("mem_wdata", mem_wdata, iss_data);
            rr0 = ev0 && rsp_ready_0;
            rr1 = ev1 && rsp_ready_1;
            tick();
            n++;
            if (issue_left > 0) issue_left--;
            if (rr0 || rr1) await_rsp = 0;
            if (e_r0 || e_r1) begin
                p = e_r1;
                r = p ? q1[0] : q0[0];
                grant_log.push_back(int'(p));
                turn       = ~p;
                issue_left = 1;
                iss_we     = r.we;
                iss_addr   = r.addr;
                iss_data   = r.wdata;
                if (r.we) begin
                    mem_ref[r.addr] = r.wdata;
                end else begin
                    await_rsp  = 1;
                    await_port = p;
                    await_data = mem_ref[r.addr];
                end
                if (p) begin void'(q1.pop_front()); v1 = 0; end
                else   begin void'(q0.pop_front()); v0 = 0; end
            end
        end
        idle_inputs();
        done = (q0.size() == 0 && q1.size() == 0 && issue_left == 0 && !await_rsp);
        check("drain_within_budget", done, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        req_t r;
        idle_inputs();
        for (int i = 0; i < 128; i++) begin
            mem[i]     = {8'hA5, 32'hC0DE_0000 + i, 32'h0};
            mem_ref[i] = {8'hA5, 32'hC0DE_0000 + i, 32'h0};
        end
        model_reset();

        // 1: reset state
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 72'h0);
        check("rst_mem_wdata", mem_wdata, 72'h0);
        check("rst_rsp_valid_0", rsp_valid_0, 1'b0);
        check("rst_rsp_valid_1", rsp_valid_1, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 72'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_req_ready_0", req_ready_0, 1'b0);
        check("rst_req_ready_1", req_ready_1, 1'b0);
        tick();

        // 2: port 0 write addr 6 data 3C
        req_valid_0 = 1; req_we_0 = 1; req_addr_0 = 7'd6; req_wdata_0 = 72'h3C;
        #1;
        check("s2_req_ready_0", req_ready_0, 1'b1);
        check("s2_req_ready_1", req_ready_1, 1'b0);
        tick();
        req_valid_0 = 0;
        #1;
        check("s2_mem_we", mem_we, 1'b1);
        check("s2_mem_addr", mem_addr, 72'd6);
        check("s2_mem_wdata", mem_wdata, 72'h3C);
        check("s2_ready_in_issue", req_ready_0, 1'b0);
        check("s2_rsp_valid_0", rsp_valid_0, 1'b0);
        check("s2_rsp_valid_1", rsp_valid_1, 1'b0);
        tick();
        check("s2_mem_we_off", mem_we, 1'b0);
        check("s2_addr_hold", mem_addr, 72'd6);
        check("s2_busy_off", busy, 1'b0);
        check("s2_mem_written", mem[6], 72'h3C);
        mem_ref[6] = 72'h3C;

        // 3: port 1 read addr 6, response stalled 3 cycles
        req_valid_1 = 1; req_we_1 = 0; req_addr_1 = 7'd6; rsp_ready_1 = 0;
        #1;
        check("s3_req_ready_1", req_ready_1, 1'b1);
        check("s3_req_ready_0", req_ready_0, 1'b0);
        tick();
        req_valid_1 = 0;
        #1;
        check("s3_issue_mem_we", mem_we, 1'b0);
        check("s3_issue_rsp_valid_1", rsp_valid_1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("s3_rsp_valid_1", rsp_valid_1, 1'b1);
            check("s3_rsp_rdata", rsp_rdata, 72'h3C);
            check("s3_rsp_valid_0", rsp_valid_0, 1'b0);
        end
        rsp_ready_1 = 1;
        tick();
        rsp_ready_1 = 0;
        check("s3_rsp_valid_1_clr", rsp_valid_1, 1'b0);
        check("s3_busy_off", busy, 1'b0);

        // 1b: reset asserted while mem_we is high
        req_valid_0 = 1; req_we_0 = 1; req_addr_0 = 7'd20; req_wdata_0 = 72'h1234;
        tick();
        req_valid_0 = 0;
        check("rstw_mem_we_pre", mem_we, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("rstw_mem_we_async", mem_we, 1'b0);
        check("rstw_busy", busy, 1'b0);
        tick();
        check("rstw_no_write", mem[20], mem_ref[20]);
        reset = 1'b1;
        model_reset();
        tick();

        // 4: both ports write every cycle from reset
        wlog_addr.delete(); wlog_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            r.we = 1; r.addr = 7'(1 + i);  r.wdata = {8'h00, $urandom, $urandom}; q0.push_back(r);
            r.we = 1; r.addr = 7'(9 + i);  r.wdata = {8'h11, $urandom, $urandom}; q1.push_back(r);
        end
        run_ports(1'b0, 100);
        check("s4_write_count", wlog_addr.size(), 6);
        if (wlog_addr.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check("s4_write_order", wlog_addr[i], (i % 2 == 0) ? 72'(1 + i / 2) : 72'(9 + i / 2));
                if (i > 0) check("s4_write_spacing", wlog_cyc[i] - wlog_cyc[i-1], 72'd2);
            end
        end

        // 5: port 0 alone, back-to-back writes
        wlog_addr.delete(); wlog_cyc.delete();
        for (int i = 0; i < 5; i++) begin
            r.we = 1; r.addr = 7'(40 + i); r.wdata = {8'h22, $urandom, $urandom}; q0.push_back(r);
        end
        run_ports(1'b0, 100);
        check("s5_write_count", wlog_addr.size(), 5);
        if (wlog_addr.size() == 5) begin
            for (int i = 1; i < 5; i++) begin
                check("s5_write_addr", wlog_addr[i], 72'(40 + i));
                check("s5_write_spacing", wlog_cyc[i] - wlog_cyc[i-1], 72'd2);
            end
        end

        // 6: reset during RESP of a port 0 read
        req_valid_0 = 1; req_we_0 = 0; req_addr_0 = 7'd6;
        tick();
        req_valid_0 = 0;
        tick();
        check("s6_rsp_valid_0_pre", rsp_valid_0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("s6_rsp_valid_0_async", rsp_valid_0, 1'b0);
        check("s6_busy", busy, 1'b0);
        check("s6_rsp_rdata", rsp_rdata, 72'h0);
        tick();
        reset = 1'b1;
        model_reset();
        tick();
        r.we = 1; r.addr = 7'd50; r.wdata = 72'h50; q0.push_back(r);
        r.we = 1; r.addr = 7'd51; r.wdata = 72'h51; q1.push_back(r);
        run_ports(1'b0, 100);
        check("s6_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 72'd0);

        // Randomized mixed traffic with random response back-pressure
        for (int i = 0; i < 80; i++) begin
            r.we    = 1'($urandom_range(0, 1));
            r.addr  = 7'($urandom_range(0, 15));
            r.wdata = {8'($urandom), $urandom, $urandom};
            if ($urandom_range(0, 1) == 0) q0.push_back(r);
            else                           q1.push_back(r);
        end
        run_ports(1'b1, 4000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
